// File: rtl/ldiv_arbiter.sv
// ldiv_arbiter: round-robin front end that shares one pipelined long divider
// among NUM_REQ requesters, with per-requester credit limits and a reset
// tag pipeline that returns each result to its requester in issue order.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   issue_en              0 blocks new grants; in-flight work still completes
//   req_valid/req_ready   per-requester request / combinational one-hot grant
//   req_numerator         packed operands, requester i at slice i
//   req_denominator       packed operands, requester i at slice i
//   rsp_valid             one-cycle pulse per result
//   rsp_id                requester index of the result
//   rsp_quotient          quotient of the result
//   rsp_remainder         remainder of the result
//   rsp_div_zero          only with LDIV_ARBITER_DIVZERO_EN: result had denominator 0
//   busy                  at least one operation in flight
//
// Optional feature macro: LDIV_ARBITER_DIVZERO_EN

// ldiv: restoring long divider, one quotient bit per stage, no reset.
// Operands are captured on the first edge; the result is registered
// NUMERATOR_WIDTH edges later. Divide by zero yields all-ones quotient and
// remainder = numerator.
module ldiv #(
    parameter int unsigned NUMERATOR_WIDTH   = 10,
    parameter int unsigned DENOMINATOR_WIDTH = 10,
    parameter int unsigned QUOTIENT_WIDTH    = 10
) (
    input  logic                         clk,
    input  logic                         valid_in,
    input  logic [NUMERATOR_WIDTH-1:0]   numerator,
    input  logic [DENOMINATOR_WIDTH-1:0] denominator,
    output logic [QUOTIENT_WIDTH-1:0]    quotient,
    output logic [NUMERATOR_WIDTH-1:0]   remainder
);
    localparam int unsigned NW  = NUMERATOR_WIDTH;
    localparam int unsigned RMW = (NW > DENOMINATOR_WIDTH) ? NW : DENOMINATOR_WIDTH;

    logic           vld   [NW];
    logic [NW-1:0]  num   [NW];
    logic [RMW-1:0] den   [NW];
    logic [RMW-1:0] rem   [NW];
    logic [NW-1:0]  quo   [NW];
    logic [RMW:0]   trial [NW];
    logic [RMW:0]   diff  [NW];
    logic           ge    [NW];
    logic [NW-1:0]  quo_out;
    logic [NW-1:0]  rem_out;

    // Stage s consumes numerator bit NW-1-s.
    always_comb begin
        for (int unsigned s = 0; s < NW; s++) begin
            trial[s] = {rem[s], num[s][NW-1-s]};
            diff[s]  = trial[s] - {1'b0, den[s]};
            ge[s]    = (trial[s] >= {1'b0, den[s]});
        end
    end

    // Stages only advance for valid entries, so idle cycles do not toggle data.
    always_ff @(posedge clk) begin
        vld[0] <= valid_in;
        if (valid_in) begin
            num[0] <= numerator;
            den[0] <= RMW'(denominator);
            rem[0] <= '0;
            quo[0] <= '0;
        end
        for (int unsigned s = 1; s < NW; s++) begin
            vld[s] <= vld[s-1];
            if (vld[s-1]) begin
                num[s] <= num[s-1];
                den[s] <= den[s-1];
                rem[s] <= ge[s-1] ? RMW'(diff[s-1]) : RMW'(trial[s-1]);
                quo[s] <= quo[s-1] | (ge[s-1] ? (NW'(1) << (NW - s)) : '0);
            end
        end
        if (vld[NW-1]) begin
            rem_out <= ge[NW-1] ? NW'(diff[NW-1]) : NW'(trial[NW-1]);
            quo_out <= quo[NW-1] | NW'(ge[NW-1]);
        end
    end

    assign quotient  = QUOTIENT_WIDTH'(quo_out);
    assign remainder = rem_out;
endmodule

module ldiv_arbiter #(
    parameter int unsigned NUM_REQ           = 4,
    parameter int unsigned NUMERATOR_WIDTH   = 10,
    parameter int unsigned DENOMINATOR_WIDTH = 10,
    parameter int unsigned QUOTIENT_WIDTH    = 10,
    parameter int unsigned MAX_OUTSTANDING   = 4
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   issue_en,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*NUMERATOR_WIDTH-1:0]     req_numerator,
    input  logic [NUM_REQ*DENOMINATOR_WIDTH-1:0]   req_denominator,
    output logic                                   rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]             rsp_id,
    output logic [QUOTIENT_WIDTH-1:0]              rsp_quotient,
    output logic [NUMERATOR_WIDTH-1:0]             rsp_remainder,
`ifdef LDIV_ARBITER_DIVZERO_EN
    output logic                                   rsp_div_zero,
`endif
    output logic                                   busy
);
    localparam int unsigned NR = NUM_REQ;
    localparam int unsigned NW = NUMERATOR_WIDTH;
    localparam int unsigned DW = DENOMINATOR_WIDTH;
    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

    logic [IW-1:0] rr_ptr;
    logic [CW-1:0] outstanding [NR];
    logic [NR-1:0] eligible;
    logic          grant_any;
    logic [IW-1:0] grant_idx;

    logic [NW-1:0] num_slice [NR];
    logic [DW-1:0] den_slice [NR];
    logic [NW-1:0] num_hold, div_num;
    logic [DW-1:0] den_hold, div_den;
    logic [QUOTIENT_WIDTH-1:0] div_quo;
    logic [NW-1:0]             div_rem;

    // Tag entry k is valid k edges after the accept; entry NW lines up with
    // the divider's registered result.
    logic          tag_vld [NW+1];
    logic [IW-1:0] tag_id  [NW+1];
`ifdef LDIV_ARBITER_DIVZERO_EN
    logic          tag_dz  [NW+1];
`endif

    for (genvar g = 0; g < NR; g++) begin : g_unpack
        assign num_slice[g] = req_numerator[g*NW +: NW];
        assign den_slice[g] = req_denominator[g*DW +: DW];
    end

    // A credit returning this cycle may be reused by a same-cycle accept,
    // so a requester at the limit can re-issue on its return edge.
    always_comb begin
        for (int unsigned i = 0; i < NR; i++) begin
            eligible[i] = issue_en && req_valid[i] &&
                          ((outstanding[i] < MAX_C) || (rsp_valid && (rsp_id == IW'(i))));
        end
    end

    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        for (int unsigned off = 0; off < NR; off++) begin
            idx = (32'(rr_ptr) + off) % NR;
            if (!grant_any && eligible[IW'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = IW'(idx);
            end
        end
        if (grant_any) req_ready[grant_idx] = 1'b1;
    end

    assign div_num = grant_any ? num_slice[grant_idx] : num_hold;
    assign div_den = grant_any ? den_slice[grant_idx] : den_hold;

    ldiv #(
        .NUMERATOR_WIDTH   (NW),
        .DENOMINATOR_WIDTH (DW),
        .QUOTIENT_WIDTH    (QUOTIENT_WIDTH)
    ) u_ldiv (
        .clk         (clk),
        .valid_in    (grant_any),
        .numerator   (div_num),
        .denominator (div_den),
        .quotient    (div_quo),
        .remainder   (div_rem)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr        <= '0;
            num_hold      <= '0;
            den_hold      <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
`ifdef LDIV_ARBITER_DIVZERO_EN
            rsp_div_zero  <= 1'b0;
`endif
            for (int unsigned k = 0; k <= NW; k++) begin
                tag_vld[k] <= 1'b0;
                tag_id[k]  <= '0;
`ifdef LDIV_ARBITER_DIVZERO_EN
                tag_dz[k]  <= 1'b0;
`endif
            end
            for (int unsigned i = 0; i < NR; i++) outstanding[i] <= '0;
        end else begin
            if (grant_any) begin
                rr_ptr   <= (grant_idx == IW'(NR - 1)) ? '0 : grant_idx + 1'b1;
                num_hold <= div_num;
                den_hold <= div_den;
            end

            tag_vld[0] <= grant_any;
            tag_id[0]  <= grant_idx;
`ifdef LDIV_ARBITER_DIVZERO_EN
            tag_dz[0]  <= grant_any && (div_den == '0);
`endif
            for (int unsigned k = 1; k <= NW; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
`ifdef LDIV_ARBITER_DIVZERO_EN
                tag_dz[k]  <= tag_dz[k-1];
`endif
            end

            rsp_valid <= tag_vld[NW];
`ifdef LDIV_ARBITER_DIVZERO_EN
            rsp_div_zero <= tag_vld[NW] && tag_dz[NW];
`endif
            if (tag_vld[NW]) begin
                rsp_id        <= tag_id[NW];
                rsp_quotient  <= div_quo;
                rsp_remainder <= div_rem;
            end

            for (int unsigned i = 0; i < NR; i++) begin
                if ((grant_any && (grant_idx == IW'(i))) && !(rsp_valid && (rsp_id == IW'(i))))
                    outstanding[i] <= outstanding[i] + 1'b1;
                else if (!(grant_any && (grant_idx == IW'(i))) && (rsp_valid && (rsp_id == IW'(i))))
                    outstanding[i] <= outstanding[i] - 1'b1;
            end
        end
    end

    always_comb begin
        busy = rsp_valid;
        for (int unsigned k = 0; k <= NW; k++) busy = busy | tag_vld[k];
    end
endmodule

// File: tb/tb_ldiv_arbiter.sv
module tb_ldiv_arbiter;
    localparam int unsigned NR   = 4;
    localparam int unsigned NW   = 4;
    localparam int unsigned DW   = 3;
    localparam int unsigned QW   = 4;
    localparam int unsigned MAXO = 2;
    localparam int unsigned IW   = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              issue_en = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*NW-1:0]  req_numerator = '0;
    logic [NR*DW-1:0]  req_denominator = '0;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [QW-1:0]     rsp_quotient;
    logic [NW-1:0]     rsp_remainder;
    logic              busy;
`ifdef LDIV_ARBITER_DIVZERO_EN
    logic              rsp_div_zero;
`endif

    ldiv_arbiter #(
        .NUM_REQ           (NR),
        .NUMERATOR_WIDTH   (NW),
        .DENOMINATOR_WIDTH (DW),
        .QUOTIENT_WIDTH    (QW),
        .MAX_OUTSTANDING   (MAXO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .issue_en        (issue_en),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_numerator   (req_numerator),
        .req_denominator (req_denominator),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_quotient    (rsp_quotient),
        .rsp_remainder   (rsp_remainder),
`ifdef LDIV_ARBITER_DIVZERO_EN
        .rsp_div_zero    (rsp_div_zero),
`endif
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int unsigned ecount = 0;
    always @(posedge clk) ecount++;

    typedef struct {
        int unsigned id;
        int unsigned q;
        int unsigned r;
        bit          dz;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    exp_t        flight[$];
    int unsigned cnt [NR];
    int unsigned ptr = 0;
    int          errors = 0;
    int          checks = 0;
    logic [NW-1:0] num_a [NR];
    logic [DW-1:0] den_a [NR];

    task automatic check(input string name, input int unsigned act, input int unsigned want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, ecount, act, want);
        end
    endtask

    // One clock of stimulus. The reference model decides the grant from the
    // round-robin and credit rules, then schedules the expected result.
    task automatic drive_cycle(input logic [NR-1:0] v, input logic en, input bit rnd);
        int unsigned n;
        int          g;
        int unsigned i;
        int unsigned ret [NR];
        int unsigned want_ready;
        exp_t        e;
        @(negedge clk);
        #1;
        n = ecount;
        if (rnd) begin
            for (int k = 0; k < NR; k++) begin
                num_a[k] = NW'($urandom);
                den_a[k] = DW'($urandom);
            end
        end
        req_numerator   = '0;
        req_denominator = '0;
        for (int k = 0; k < NR; k++) begin
            req_numerator   = req_numerator   | ((NR*NW)'(num_a[k]) << (k*NW));
            req_denominator = req_denominator | ((NR*DW)'(den_a[k]) << (k*DW));
        end
        req_valid = v;
        issue_en  = en;
        #1;
        while (flight.size() > 0 && flight[0].due < n) void'(flight.pop_front());
        check("busy", busy, (flight.size() > 0) ? 1 : 0);
        for (int k = 0; k < NR; k++) ret[k] = 0;
        foreach (flight[k]) if (flight[k].due == n) ret[flight[k].id] = 1;
        g = -1;
        for (int unsigned off = 0; off < NR; off++) begin
            i = (ptr + off) % NR;
            if (g < 0 && v[i] && en && (cnt[i] - ret[i]) < MAXO) g = int'(i);
        end
        want_ready = (g >= 0) ? (1 << g) : 0;
        check("req_ready", req_ready, want_ready);
        for (int k = 0; k < NR; k++) cnt[k] -= ret[k];
        if (g >= 0) begin
            cnt[g]++;
            ptr   = (g + 1) % NR;
            e.id  = g;
            e.dz  = (den_a[g] == 0);
            e.q   = e.dz ? ((1 << QW) - 1) : num_a[g] / den_a[g];
            e.r   = e.dz ? num_a[g] : num_a[g] % den_a[g];
            e.due = n + NW + 2;
            sb.push_back(e);
            flight.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        sb.delete();
        flight.delete();
        for (int k = 0; k < NR; k++) cnt[k] = 0;
        ptr = 0;
        #1;
        check("reset rsp_valid", rsp_valid, 0);
        check("reset busy", busy, 0);
        check("reset rsp_id", rsp_id, 0);
        check("reset rsp_quotient", rsp_quotient, 0);
        check("reset rsp_remainder", rsp_remainder, 0);
        @(negedge clk);
        #1;
        req_valid = '0;
        reset_n   = 1'b1;
    endtask

    task automatic idle(input int unsigned cycles);
        for (int unsigned k = 0; k < cycles; k++) drive_cycle('0, 1'b1, 1'b1);
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected rsp_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", rsp_id, e.id);
                    check("rsp_quotient", rsp_quotient, e.q);
                    check("rsp_remainder", rsp_remainder, e.r);
                    check("rsp latency", ecount, e.due);
`ifdef LDIV_ARBITER_DIVZERO_EN
                    check("rsp_div_zero", rsp_div_zero, e.dz);
`endif
                end
            end else begin
`ifdef LDIV_ARBITER_DIVZERO_EN
                check("rsp_div_zero idle", rsp_div_zero, 0);
`endif
                if (sb.size() > 0 && sb[0].due <= ecount) begin
                    check("missing rsp_valid", 0, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < NR; k++) begin
            cnt[k] = 0;
            num_a[k] = '0;
            den_a[k] = '0;
        end
        do_reset();

        // single request: 13/3 from requester 2
        num_a[2] = 4'd13;
        den_a[2] = 3'd3;
        drive_cycle(4'b0100, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) drive_cycle('0, 1'b1, 1'b0);

        // round-robin with constant operands, credit throttling
        for (int k = 0; k < NR; k++) begin
            num_a[k] = NW'(k * 3 + 5);
            den_a[k] = DW'(k + 1);
        end
        for (int k = 0; k < 20; k++) drive_cycle(4'b1111, 1'b1, 1'b0);
        idle(8);

        // credit limit with a lone requester
        for (int k = 0; k < 16; k++) drive_cycle(4'b0001, 1'b1, 1'b1);
        idle(8);

        // divide by zero
        num_a[1] = 4'd9;
        den_a[1] = 3'd0;
        drive_cycle(4'b0010, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) drive_cycle('0, 1'b1, 1'b0);

        // reset with three operations in flight
        for (int k = 0; k < 3; k++) drive_cycle(4'b1111, 1'b1, 1'b1);
        do_reset();
        idle(8);
        for (int k = 0; k < 4; k++) drive_cycle(4'b1111, 1'b1, 1'b1);

        // issue_en gating mid-stream, resume from saved pointer
        for (int k = 0; k < 2; k++) drive_cycle(4'b1111, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) drive_cycle(4'b1111, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) drive_cycle(4'b1111, 1'b1, 1'b1);

        // randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else drive_cycle(NR'($urandom), ($urandom_range(0, 7) != 0), 1'b1);
        end

        idle(NW + 6);
        check("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ldiv_arbiter.md
Name: ldiv_arbiter

Overview:
- Shares one pipelined long divider (`ldiv`) among NUM_REQ requesters.
- Round-robin arbitration with one issue per cycle; each requester has a cap on outstanding divisions.
- A reset tag pipeline runs in lockstep with the divider and routes each result back to its requester with an ID.
- Sits between request-generating blocks and the `ldiv` instance, which it instantiates internally.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUMERATOR_WIDTH, 10, numerator and remainder width.
- DENOMINATOR_WIDTH, 10, denominator width.
- QUOTIENT_WIDTH, 10, quotient width.
- MAX_OUTSTANDING, 4, maximum in-flight divisions per requester (1..15).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_en  in  1  when 0, no new grants; in-flight operations complete normally.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_numerator  in  NUM_REQ*NUMERATOR_WIDTH  packed; requester i at slice i.
- req_denominator  in  NUM_REQ*DENOMINATOR_WIDTH  packed.
- rsp_valid  out  1  result valid; single-cycle pulse per result.
- rsp_id  out  clog2(NUM_REQ)  requester index of the result.
- rsp_quotient  out  QUOTIENT_WIDTH  quotient.
- rsp_remainder  out  NUMERATOR_WIDTH  remainder.
- busy  out  1  at least one operation in flight.

Behaviour:
- Reset values: rsp_valid=0, rsp_id=0, rsp_quotient=0, rsp_remainder=0, busy=0, RR pointer=0, all credit counters=0, tag pipeline cleared.
- Reset is asserted asynchronously. Deassertion is synchronised by the integrator.
- Eligibility: requester i is eligible when req_valid[i]=1, outstanding[i] < MAX_OUTSTANDING and issue_en=1.
- Grant: req_ready is combinational. It selects the first eligible index starting at the RR pointer, with wrap-around. At most one bit is set.
- Accept: req_valid[i] & req_ready[i] at an edge. The selected operands and valid_in=1 are presented to `ldiv` that cycle. If no grant, valid_in=0 and operands are held at the last value.
- RR pointer: after an accept by i, pointer = (i+1) mod NUM_REQ. With no accept, the pointer is unchanged.
- Tag pipeline: shift register of {valid, id}, NUMERATOR_WIDTH+1 entries deep. It aligns with the `ldiv` output stage and is reset by reset_n.
  - `ldiv` itself has no reset, so its valid_out is not used.
- Response registers load on the edge after the aligned tag valid.
  - Latency: accept at edge T gives rsp_valid=1 for the cycle after edge T+NUMERATOR_WIDTH+1.
  - Throughput: 1 result/cycle; results return in issue order.
- Credits: outstanding[i] increments on accept by i and decrements on the rsp_valid edge with rsp_id=i. When both happen in one cycle, it is unchanged. It never exceeds MAX_OUTSTANDING and never underflows.
- busy = (any tag valid) OR rsp_valid.
- Divide by zero: passes through `ldiv` unchanged. Result is quotient = all ones (QUOTIENT_WIDTH), remainder = numerator. Not flagged unless the optional feature is enabled.
- issue_en falling mid-stream: grants stop that cycle; outstanding results are still delivered.
- Reset mid-operation: in-flight results are discarded, no rsp_valid pulses follow, credits return to 0.
- Operand changes while req_ready=0 have no effect. The block holds no request state across cycles.

Optional Feature:
- Macro: LDIV_ARBITER_DIVZERO_EN.
- Defined:
  - Adds output port rsp_div_zero (1 bit), reset 0.
  - A per-entry flag (denominator==0 at accept) is carried in the tag pipeline.
  - rsp_div_zero is valid with rsp_valid and is 0 when rsp_valid=0.
- Undefined: the port, flag bit and comparator do not exist. Data behaviour is identical.

Test Plan (NUMERATOR_WIDTH=4, DENOMINATOR_WIDTH=3, QUOTIENT_WIDTH=4, NUM_REQ=4, MAX_OUTSTANDING=2):
- Single request: req 2 issues 13/3 at edge T -> rsp_valid in the cycle after edge T+5, rsp_id=2, quotient=4, remainder=1; busy drops the following cycle.
- Round-robin: all four requesters hold valid with constant operands -> grants 0,1,2,3,0,...
  - Each requester throttles after 2 accepts until its first response returns.
  - Results arrive in issue order with the correct id.
- Credit limit: req 0 holds valid alone -> two accepts on consecutive cycles, then req_ready[0]=0 until rsp_id=0 returns.
  - On that return edge, a simultaneous re-accept is allowed and the count stays at 2.
- Divide by zero: req 1 issues 9/0 -> quotient=15, remainder=9; with LDIV_ARBITER_DIVZERO_EN defined, rsp_div_zero=1.
- Reset mid-flight: three operations in flight, reset_n pulsed low -> outputs go to 0 immediately; no rsp_valid afterwards; all requesters eligible again.
- issue_en=0 with all req_valid=1 -> req_ready=0. Prior results still return; on re-enable, grants resume from the saved pointer.
